// File: rtl/axis_sync_fifo_lvl_pkg.sv
// Shared helpers for the level-reporting AXI-Stream FIFO.
package axis_sync_fifo_lvl_pkg;

    // Storage address width for a FIFO of the given total depth (never below 1 bit).
    function automatic int addr_width(input int depth);
        int w;
        w = $clog2(depth - 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream interface: valid/ready handshake plus data.
interface axis_if #(
    parameter int TDATA_WIDTH = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/ram_async.sv
// Simple dual-port RAM: synchronous write, asynchronous (combinational) read.
module ram_async #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port: contents carry no reset, stale entries are never read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/axis_sync_fifo_lvl.sv
// Synchronous AXI-Stream FIFO with a registered output stage, fill-level count,
// almost-full/almost-empty flags and a synchronous flush. Any DEPTH >= 2.
module axis_sync_fifo_lvl
    import axis_sync_fifo_lvl_pkg::*;
#(
    parameter int TDATA_WIDTH = 8,
    parameter int DEPTH       = 6,
    parameter int AF_THRESH   = DEPTH - 1,
    parameter int AE_THRESH   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axis_if.s                            axis_sif,
    axis_if.m                            axis_mif,
    input  logic                         invalidate,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         almost_empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = addr_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 2);

    if (TDATA_WIDTH < 1 || $bits(axis_sif.tdata) != TDATA_WIDTH ||
        $bits(axis_mif.tdata) != TDATA_WIDTH) begin : g_bad_width
        $fatal(1, "axis_sync_fifo_lvl: TDATA_WIDTH must be > 0 and match both interfaces");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "axis_sync_fifo_lvl: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_thresh
        $fatal(1, "axis_sync_fifo_lvl: threshold out of range");
    end

    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic                   tvalid_q, tvalid_d, tready_q, tready_d;
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d, rd_data;
    logic                   push, pop, stor_empty, to_out, we;

    // Pointer increment with explicit wrap at the last storage slot.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    ram_async #(
        .DATA_WIDTH(TDATA_WIDTH),
        .ADDR_WIDTH(PTR_W),
        .DEPTH     (DEPTH - 1)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(wptr_q),
        .wdata(axis_sif.tdata),
        .raddr(rptr_q),
        .rdata(rd_data)
    );

    // Next-state: output register is the queue head, storage holds everything behind it.
    always_comb begin
        push       = axis_sif.tvalid && tready_q;
        pop        = tvalid_q && axis_mif.tready;
        // count includes the output register, so storage is empty below 2
        stor_empty = (count_q < CNT_W'(2));
        to_out     = push && (!tvalid_q || (pop && stor_empty));
        we         = 1'b0;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tready_d   = tready_q;
        if (invalidate) begin
            count_d  = '0;
            wptr_d   = '0;
            rptr_d   = '0;
            tvalid_d = 1'b0;
            tready_d = 1'b1;
        end else begin
            if (to_out) begin
                tdata_d  = axis_sif.tdata;
                tvalid_d = 1'b1;
            end else if (pop) begin
                if (!stor_empty) begin
                    tdata_d = rd_data;
                    rptr_d  = ptr_inc(rptr_q);
                end else begin
                    tvalid_d = 1'b0;
                end
            end
            if (push && !to_out) begin
                we     = 1'b1;
                wptr_d = ptr_inc(wptr_q);
            end
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            tready_d = (count_d < DEPTH_C);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            tvalid_q <= 1'b0;
            tready_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            count_q  <= count_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            tvalid_q <= tvalid_d;
            tready_q <= tready_d;
            tdata_q  <= tdata_d;
        end
    end

    assign axis_sif.tready = tready_q;
    assign axis_mif.tvalid = tvalid_q;
    assign axis_mif.tdata  = tdata_q;
    assign count           = count_q;
    assign almost_full     = (count_q >= AF_C);
    assign almost_empty    = (count_q <= AE_C);

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count_q <= DEPTH_C);
    a_valid_level: assert property (@(posedge clk) disable iff (!rst_n) tvalid_q == (count_q != '0));
endmodule

// File: tb/tb_axis_sync_fifo_lvl.sv
// Randomised and directed bench for axis_sync_fifo_lvl against a queue model.
module tb_axis_sync_fifo_lvl;
    localparam int DEPTH = 6;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int W     = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       invalidate;
    logic [2:0] count;
    logic       almost_full, almost_empty;
    bit         cmp_en = 1'b0;
    int         total = 0;
    int         bad = 0;

    axis_if #(.TDATA_WIDTH(W)) s_if ();
    axis_if #(.TDATA_WIDTH(W)) m_if ();

    axis_sync_fifo_lvl #(
        .TDATA_WIDTH(W),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .axis_sif    (s_if),
        .axis_mif    (m_if),
        .invalidate  (invalidate),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    // Reference: a plain queue whose head is what the consumer must see.
    logic [W-1:0] q[$];
    bit           mdl_rdy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit psh;
        bit pp;
        if (!rst_n) begin
            q.delete();
            mdl_rdy = 1'b0;
        end else begin
            psh = s_if.tvalid && mdl_rdy;
            pp  = (q.size() > 0) && m_if.tready;
            if (invalidate) begin
                q.delete();
            end else begin
                if (pp) void'(q.pop_front());
                if (psh) q.push_back(s_if.tdata);
            end
            mdl_rdy = (q.size() < DEPTH);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_tvalid", {31'b0, m_if.tvalid}, (q.size() > 0) ? 1 : 0);
            chk("s_tready", {31'b0, s_if.tready}, {31'b0, mdl_rdy});
            chk("count", {29'b0, count}, q.size());
            chk("almost_full", {31'b0, almost_full}, (q.size() >= AF) ? 1 : 0);
            chk("almost_empty", {31'b0, almost_empty}, (q.size() <= AE) ? 1 : 0);
            if (q.size() > 0) chk("m_tdata", {24'b0, m_if.tdata}, {24'b0, q[0]});
        end
    end

    int exp_ae[6] = '{1, 1, 0, 0, 0, 0};
    int exp_af[6] = '{0, 0, 0, 0, 1, 1};

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;
        invalidate  = 1'b0;

        // reset state
        #3;
        chk("rst_tvalid", {31'b0, m_if.tvalid}, 0);
        chk("rst_tdata", {24'b0, m_if.tdata}, 0);
        chk("rst_tready", {31'b0, s_if.tready}, 0);
        chk("rst_count", {29'b0, count}, 0);
        chk("rst_af", {31'b0, almost_full}, 0);
        chk("rst_ae", {31'b0, almost_empty}, 1);
        cmp_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("tready_after_rst", {31'b0, s_if.tready}, 1);

        // single word, 1-cycle latency
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'hA5;
        @(negedge clk);
        s_if.tvalid = 1'b0;
        chk("one_tvalid", {31'b0, m_if.tvalid}, 1);
        chk("one_tdata", {24'b0, m_if.tdata}, 32'hA5);
        chk("one_count", {29'b0, count}, 1);
        @(negedge clk);
        chk("one_count_after_pop", {29'b0, count}, 0);

        // fill to full with the consumer stalled
        m_if.tready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            chk("fill_count", {29'b0, count}, k);
            chk("fill_ae", {31'b0, almost_empty}, exp_ae[k]);
            chk("fill_af", {31'b0, almost_full}, exp_af[k]);
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'(k);
            @(negedge clk);
        end
        chk("full_count", {29'b0, count}, 6);
        chk("full_tready", {31'b0, s_if.tready}, 0);
        chk("full_af", {31'b0, almost_full}, 1);
        chk("full_model_size", q.size(), 6);
        s_if.tdata = 8'h77;
        repeat (2) @(negedge clk);
        chk("full_no_seventh", {29'b0, count}, 6);
        s_if.tvalid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            chk("drain_order", {24'b0, m_if.tdata}, k);
            if (k == 1) begin
                chk("after_pop_count", {29'b0, count}, 5);
                chk("after_pop_tready", {31'b0, s_if.tready}, 1);
            end
            m_if.tready = 1'b1;
            @(negedge clk);
        end
        chk("drained_tvalid", {31'b0, m_if.tvalid}, 0);

        // flush with simultaneous push and pop
        m_if.tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'h10 + 8'(k);
            @(negedge clk);
        end
        chk("pre_inv_count", {29'b0, count}, 4);
        s_if.tdata  = 8'hEE;
        m_if.tready = 1'b1;
        invalidate  = 1'b1;
        @(negedge clk);
        invalidate  = 1'b0;
        s_if.tvalid = 1'b0;
        chk("inv_count", {29'b0, count}, 0);
        chk("inv_tvalid", {31'b0, m_if.tvalid}, 0);
        chk("inv_tready", {31'b0, s_if.tready}, 1);
        repeat (3) begin
            @(negedge clk);
            chk("inv_no_ghost", {31'b0, m_if.tvalid}, 0);
        end

        // randomised traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            s_if.tvalid = ($urandom_range(0, 3) != 0);
            s_if.tdata  = 8'($urandom);
            m_if.tready = ($urandom_range(0, 2) != 0) || (c > 200 && c < 230 ? 1'b0 : 1'b0);
            if (c > 250 && c < 300) m_if.tready = ($urandom_range(0, 4) == 0);
            invalidate  = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        invalidate = 1'b1;
        s_if.tvalid = 1'b0;
        @(negedge clk);
        invalidate = 1'b0;

        // asynchronous reset mid-stream
        m_if.tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'h31 + 8'(k);
            @(negedge clk);
        end
        s_if.tvalid = 1'b0;
        chk("pre_rst_count", {29'b0, count}, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", {31'b0, m_if.tvalid}, 0);
        chk("async_rst_tready", {31'b0, s_if.tready}, 0);
        chk("async_rst_count", {29'b0, count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tready", {31'b0, s_if.tready}, 1);
        chk("post_rst_count", {29'b0, count}, 0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h3C;
        m_if.tready = 1'b1;
        @(negedge clk);
        s_if.tvalid = 1'b0;
        chk("post_rst_first_tvalid", {31'b0, m_if.tvalid}, 1);
        chk("post_rst_first_tdata", {24'b0, m_if.tdata}, 32'h3C);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
